dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port `data_memory` (32-bit address/data, `mem_read`/`mem_write`, 2-bit `store_signal`) between the CPU load/store path (port 0) and a secondary requester such as a loader or debug/DMA engine (port 1). It grants the memory round-robin, supports bounded locked bursts, and drives the memory's control and data inputs. It returns `read_data` and a single-cycle ack to the owner. It sits between the requesters and `data_memory`. Memory reads are combinational from `mem_address`; writes commit at `posedge clk`.

## Interface
- `MAX_BURST`, 4: maximum consecutive accesses per locked ownership, legal range 1..15.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  access request; held until ack.
- `m0_addr`, `m1_addr`  in  32  word address.
- `m0_wdata`, `m1_wdata`  in  32  store data.
- `m0_we`, `m1_we`  in  1  store.
- `m0_re`, `m1_re`  in  1  load.
- `m0_store`, `m1_store`  in  2  store width code, passed through to `store_signal`.
- `m0_lock`, `m1_lock`  in  1  keep ownership for the next access.
- `m0_ack`, `m1_ack`  out  1  access performed this cycle.
- `m0_rdata`, `m1_rdata`  out  32  load data, valid while ack is high.
- `mem_address`  out  32  to `data_memory`.
- `write_data`  out  32  to `data_memory`.
- `mem_read`  out  1  to `data_memory`.
- `mem_write`  out  1  to `data_memory`.
- `store_signal`  out  2  to `data_memory`.
- `read_data`  in  32  from `data_memory`.
- `owner`  out  2  current state: 00 IDLE, 01 port 0, 10 port 1.

## Operation
- **State**
  - FSM states: IDLE, OWN0, OWN1.
  - `last`: 1 bit, port served most recently.
  - `bcnt`: 4 bits, accesses completed in the current locked burst.
- **IDLE**
  - All memory outputs are 0 and both acks are 0.
  - At the clock edge:
    - Only `m0_req` high: go to OWN0.
    - Only `m1_req` high: go to OWN1.
    - Both high: grant the port ≠ `last`.
    - Neither high: stay in IDLE.
- **OWNx**
  - Memory outputs combinationally mirror port x's address, wdata and store code.
  - `mem_write = mx_req & mx_we`.
  - `mem_read = mx_req & mx_re & ~mx_we`; write wins if both `we` and `re` are high.
  - `mx_ack = mx_req`.
  - `mx_rdata = read_data` while ack is high, else 0.
  - The other port's ack and rdata are 0.
- **OWNx edge decision**, in priority order:
  1. `mx_req = 0`: go to IDLE, `bcnt` ← 0, no access performed.
  2. `mx_lock` and `bcnt < MAX_BURST-1`: stay in OWNx, `bcnt` ← `bcnt+1`, `last` ← x.
  3. Other port requesting: go to OWN(other), `bcnt` ← 0, `last` ← x.
  4. Otherwise: go to IDLE, `bcnt` ← 0, `last` ← x.
- **Requester rule**
  - After ack, a requester either drops `req` or presents its next transaction in the following cycle.
  - A non-locked requester never sees back-to-back acks.
- A port with no `re` and no `we` while acked is a null access; it is acked and consumes a grant.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - State IDLE, `last` = 1 (port 0 wins the first tie), `bcnt` = 0.
  - All outputs 0, including `owner` = 00.
- Reset asserted mid-access forces IDLE immediately; any write not yet at its clock edge is dropped.
- **Latency**
  - Request seen at edge N; ack during cycle N+1; write commits at the edge ending cycle N+1.
  - Load data is valid combinationally in cycle N+1.
- **Throughput**
  - Locked burst: one access per cycle for up to `MAX_BURST` accesses.
  - Alternating contenders: one access per cycle.
  - Single non-locked requester: one access per 2 cycles, through IDLE.
- **Burst limit**
  - With `MAX_BURST` = 1, lock is ignored.
  - After `MAX_BURST` accesses, ownership passes to the other port if it is requesting, even while the owner holds `lock`.
- Inputs from a non-owner are ignored. Its `req` stays pending, with no ack, until granted.

## Test plan
- **Reset and tie-break:** reset, then both ports request reads of addresses 1 and 2 in the same cycle → `owner` = 01, then `m0_ack` with `m0_rdata` = mem[1]; next cycle `owner` = 10, `m1_ack` with mem[2].
- **Store and read-back:** port 0 stores `32'hFDFFFFFF` to address 1 with `store` = 00, then loads address 1 → `mem_write` high for exactly one cycle, then `m0_rdata` = `32'hFDFFFFFF`.
- **Burst limit:** `MAX_BURST` = 4; port 1 locked with 6 queued writes while port 0 requests → 4 consecutive `m1_ack`, then `owner` = 01 and `m0_ack`, then port 1 resumes.
- **Async reset mid-access:** assert `rst_n` low while `owner` = 01 with `m0_we` high → outputs 0 immediately and memory unchanged at the next edge.
- **Read/write conflict:** `m0_we` = `m0_re` = 1 → `mem_write` = 1, `mem_read` = 0.
- **Pending non-owner:** port 1 raises `req` during a port 0 burst → no `m1_ack` and no memory activity from port 1 until `owner` = 10.

Source files
------------

// File: rtl/dmem_arbiter.sv
//============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter with bounded locked bursts that shares a
//               single-port data memory between two requesters.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic        m0_re,
    input  logic [1:0]  m0_store,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_re,
    input  logic [1:0]  m1_store,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  store_signal,
    input  logic [31:0] read_data,
    output logic [1:0]  owner
);

    // bcnt value at which a locked owner must release
    localparam logic [3:0] c_burst_last = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OWN0 = 2'b01,
        S_OWN1 = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic [3:0]  r_bcnt;
    logic [3:0]  w_bcnt_nxt;

    logic        w_port;
    logic        w_req;
    logic        w_other_req;
    logic        w_we;
    logic        w_re;
    logic        w_lock;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_store;

    // Owner-side view of the request signals; only meaningful in OWN0/OWN1
    assign w_port      = (r_state == S_OWN1);
    assign w_req       = w_port ? m1_req   : m0_req;
    assign w_other_req = w_port ? m0_req   : m1_req;
    assign w_we        = w_port ? m1_we    : m0_we;
    assign w_re        = w_port ? m1_re    : m0_re;
    assign w_lock      = w_port ? m1_lock  : m0_lock;
    assign w_addr      = w_port ? m1_addr  : m0_addr;
    assign w_wdata     = w_port ? m1_wdata : m0_wdata;
    assign w_store     = w_port ? m1_store : m0_store;

    assign owner = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_bcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_bcnt_nxt   = r_bcnt;
        mem_address  = 32'd0;
        write_data   = 32'd0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        store_signal = 2'b00;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        m0_rdata     = 32'd0;
        m1_rdata     = 32'd0;

        case (r_state)
            S_IDLE: begin
                // On a tie, the port not served last wins
                if (m0_req && m1_req) begin
                    w_state_nxt = r_last ? S_OWN0 : S_OWN1;
                end else if (m0_req) begin
                    w_state_nxt = S_OWN0;
                end else if (m1_req) begin
                    w_state_nxt = S_OWN1;
                end
            end

            S_OWN0, S_OWN1: begin
                mem_address  = w_addr;
                write_data   = w_wdata;
                store_signal = w_store;
                mem_write    = w_req & w_we;
                mem_read     = w_req & w_re & ~w_we;
                m0_ack       = w_req & ~w_port;
                m1_ack       = w_req &  w_port;
                m0_rdata     = (w_req & ~w_port) ? read_data : 32'd0;
                m1_rdata     = (w_req &  w_port) ? read_data : 32'd0;

                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                    w_bcnt_nxt  = 4'd0;
                end else begin
                    w_last_nxt = w_port;
                    if (w_lock && (r_bcnt < c_burst_last)) begin
                        w_bcnt_nxt = r_bcnt + 4'd1;
                    end else begin
                        w_bcnt_nxt = 4'd0;
                        if (w_other_req) begin
                            w_state_nxt = w_port ? S_OWN0 : S_OWN1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_bcnt_nxt  = 4'd0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter against a tenure-based
//               reference model and a shadow memory.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, re, lock;
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [1:0]  store[2];

    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, write_data, read_data;
    logic        mem_read, mem_write;
    logic [1:0]  store_signal, owner;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_we(we[0]),
        .m0_re(re[0]), .m0_store(store[0]), .m0_lock(lock[0]),
        .m0_ack(ack0), .m0_rdata(rdata0),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_we(we[1]),
        .m1_re(re[1]), .m1_store(store[1]), .m1_lock(lock[1]),
        .m1_ack(ack1), .m1_rdata(rdata1),
        .mem_address(mem_address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .store_signal(store_signal), .read_data(read_data), .owner(owner)
    );

    // Behavioural data_memory: combinational read, write at the clock edge
    logic [31:0] dmem[16];
    assign read_data = dmem[mem_address[3:0]];
    always @(posedge clk) if (mem_write) dmem[mem_address[3:0]] <= write_data;

    // Reference model: who owns the memory, who was served last, and how
    // many accesses the current owner has made in this tenure
    int          mown;
    int          mlast;
    int          mtenure;
    logic [31:0] shadow[16];

    logic [1:0]  e_ack;
    logic [31:0] e_rdata[2];
    logic [31:0] e_addr, e_wd;
    logic        e_mw, e_mr;
    logic [1:0]  e_st, e_owner;

    logic [1:0]  s_owner;
    logic        s_ack0, s_ack1, s_mw, s_mr;
    logic [31:0] s_rdata0, s_rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mown    = 0;
        mlast   = 1;
        mtenure = 0;
    endtask

    task automatic compute_expected();
        int p;
        e_owner    = 2'(mown);
        e_ack      = 2'b00;
        e_rdata[0] = 32'd0;
        e_rdata[1] = 32'd0;
        e_addr = 32'd0; e_wd = 32'd0; e_st = 2'b00; e_mw = 1'b0; e_mr = 1'b0;
        if (mown != 0) begin
            p      = mown - 1;
            e_addr = addr[p];
            e_wd   = wdata[p];
            e_st   = store[p];
            e_mw   = req[p] & we[p];
            e_mr   = req[p] & re[p] & ~we[p];
            e_ack[p] = req[p];
            if (req[p]) e_rdata[p] = shadow[addr[p][3:0]];
        end
    endtask

    task automatic model_edge();
        int p;
        int o;
        if (mown == 0) begin
            if (req[0] && req[1]) mown = (mlast == 0) ? 2 : 1;
            else if (req[0])      mown = 1;
            else if (req[1])      mown = 2;
            mtenure = 0;
        end else begin
            p = mown - 1;
            o = 1 - p;
            if (!req[p]) begin
                mown    = 0;
                mtenure = 0;
            end else begin
                if (we[p]) shadow[addr[p][3:0]] = wdata[p];
                mlast   = p;
                mtenure = mtenure + 1;
                // A locked owner keeps the memory until it has made MAX_BURST accesses
                if (!(lock[p] && mtenure < MAX_BURST)) begin
                    mown    = req[o] ? o + 1 : 0;
                    mtenure = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compute_expected();
        check("owner",        32'(owner),        32'(e_owner));
        check("m0_ack",       32'(ack0),         32'(e_ack[0]));
        check("m1_ack",       32'(ack1),         32'(e_ack[1]));
        check("m0_rdata",     rdata0,            e_rdata[0]);
        check("m1_rdata",     rdata1,            e_rdata[1]);
        check("mem_write",    32'(mem_write),    32'(e_mw));
        check("mem_read",     32'(mem_read),     32'(e_mr));
        check("mem_address",  mem_address,       e_addr);
        check("write_data",   write_data,        e_wd);
        check("store_signal", 32'(store_signal), 32'(e_st));
        s_owner = owner; s_ack0 = ack0; s_ack1 = ack1;
        s_rdata0 = rdata0; s_rdata1 = rdata1; s_mw = mem_write; s_mr = mem_read;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic new_txn(input int p);
        req[p]   = 1'b1;
        addr[p]  = $urandom;
        wdata[p] = $urandom;
        we[p]    = 1'($urandom_range(0, 1));
        re[p]    = 1'($urandom_range(0, 1));
        store[p] = 2'($urandom_range(0, 3));
        lock[p]  = ($urandom_range(0, 2) == 0);
    endtask

    task automatic set_txn(input int p, input logic w, input logic r, input logic l,
                           input logic [31:0] a, input logic [31:0] d);
        req[p] = 1'b1; we[p] = w; re[p] = r; lock[p] = l;
        addr[p] = a; wdata[p] = d; store[p] = 2'b00;
    endtask

    initial begin
        int acks[$];
        int k;
        int wr_cnt;
        logic [31:0] old5;

        rst_n = 1'b0;
        req = 2'b00; we = 2'b00; re = 2'b00; lock = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr[p] = 32'd0; wdata[p] = 32'd0; store[p] = 2'b00;
        end
        for (int i = 0; i < 16; i++) begin
            dmem[i]   = $urandom;
            shadow[i] = dmem[i];
        end
        model_reset();

        // Outputs stay quiet in reset even with live requests
        repeat (2) @(posedge clk);
        #1;
        set_txn(0, 1'b1, 1'b0, 1'b0, 32'd3, 32'h1234_5678);
        set_txn(1, 1'b0, 1'b1, 1'b0, 32'd4, 32'h0);
        #1;
        check("rst_owner",     32'(owner),     32'd0);
        check("rst_ack0",      32'(ack0),      32'd0);
        check("rst_ack1",      32'(ack1),      32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr",  mem_address,    32'd0);
        req = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Tie-break after reset: port 0 first, then port 1
        set_txn(0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        set_txn(1, 1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
        step();
        step();
        check("tie_owner0", 32'(s_owner), 32'd1);
        check("tie_ack0",   32'(s_ack0),  32'd1);
        check("tie_rdata0", s_rdata0,     shadow[1]);
        req[0] = 1'b0;
        step();
        check("tie_owner1", 32'(s_owner), 32'd2);
        check("tie_ack1",   32'(s_ack1),  32'd1);
        check("tie_rdata1", s_rdata1,     shadow[2]);
        req[1] = 1'b0;
        step();

        // Store then read back through port 0
        wr_cnt = 0;
        set_txn(0, 1'b1, 1'b0, 1'b0, 32'd1, 32'hFDFF_FFFF);
        step();
        step();
        if (s_mw) wr_cnt++;
        set_txn(0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        step();
        if (s_mw) wr_cnt++;
        step();
        if (s_mw) wr_cnt++;
        check("store_wr_pulses", 32'(wr_cnt), 32'd1);
        check("store_readback",  s_rdata0,    32'hFDFF_FFFF);
        req[0] = 1'b0;
        step();

        // Read/write conflict: write wins
        set_txn(0, 1'b1, 1'b1, 1'b0, 32'd7, 32'hA5A5_0007);
        step();
        step();
        check("conflict_write", 32'(s_mw), 32'd1);
        check("conflict_read",  32'(s_mr), 32'd0);
        req[0] = 1'b0;
        step();

        // Burst limit: locked port 1 with six writes while port 0 waits
        k = 0;
        set_txn(1, 1'b1, 1'b0, 1'b1, 32'd10, $urandom);
        for (int c = 0; c < 14; c++) begin
            step();
            if (s_ack1) acks.push_back(1);
            if (s_ack0) acks.push_back(0);
            if (s_owner == 2'b10) check("pend_no_ack0", 32'(s_ack0), 32'd0);
            if (c == 0) set_txn(0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
            if (e_ack[0]) req[0] = 1'b0;
            if (e_ack[1]) begin
                k++;
                if (k == 6) req[1] = 1'b0;
                else begin
                    addr[1]  = 32'(10 + k);
                    wdata[1] = $urandom;
                end
            end
        end
        check("burst_ack_count", 32'(acks.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < acks.size()) check("burst_order", 32'(acks[i]), (i == 4) ? 32'd0 : 32'd1);
        end

        // Randomized contention
        for (int c = 0; c < 600; c++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (e_ack[p]) begin
                    if ($urandom_range(0, 3) == 0) req[p] = 1'b0;
                    else new_txn(p);
                end else if (!req[p] && ($urandom_range(0, 2) == 0)) begin
                    new_txn(p);
                end
            end
        end
        req = 2'b00;
        step();
        step();

        // Asynchronous reset during a port 0 write
        old5 = shadow[5];
        set_txn(0, 1'b1, 1'b0, 1'b0, 32'd5, ~old5);
        step();
        check("mid_owner_before", 32'(owner), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_owner",     32'(owner),     32'd0);
        check("mid_rst_mem_write", 32'(mem_write), 32'd0);
        check("mid_rst_ack0",      32'(ack0),      32'd0);
        check("mid_rst_wdata",     write_data,     32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("mid_rst_mem_keep", dmem[5], old5);
        req = 2'b00;
        rst_n = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
